// File: rtl/chnl_accum_if.sv
// chnl_accum_if: run control, input beat stream and output result bundle of the
// channel accumulator. The master side is the producer/consumer environment and the
// slave side is the accumulator itself.
interface chnl_accum_if #(
   parameter int unsigned NI = 9,
   parameter int unsigned IW = 32,
   parameter int unsigned NO = 7,
   parameter int unsigned OW = 32,
   parameter int unsigned LW = 16
);
   logic                start;
   logic [LW-1:0]       cfg_len;
   logic                cfg_sat;
   logic                in_valid;
   logic                in_ready;
   logic [NI*IW-1:0]    din;
   logic                out_valid;
   logic                out_ready;
   logic [NO*OW-1:0]    dout;
   logic [NO-1:0]       ovf;
   logic                busy;

   modport master (
      output start, cfg_len, cfg_sat, in_valid, din, out_ready,
      input  in_ready, out_valid, dout, ovf, busy
   );

   modport slave (
      input  start, cfg_len, cfg_sat, in_valid, din, out_ready,
      output in_ready, out_valid, dout, ovf, busy
   );
endinterface

// File: rtl/chnl_accum.sv
// chnl_accum: sums NO lanes (starting at input lane LANE_OFS) of a signed NI-lane bus
// over a run of cfg_len beats, with wrap or saturating arithmetic and a sticky
// per-lane overflow flag. Result is held on dout until the downstream handshake.
module chnl_accum #(
   parameter int unsigned NI       = 9,
   parameter int unsigned IW       = 32,
   parameter int unsigned NO       = 7,
   parameter int unsigned OW       = 32,
   parameter int unsigned LANE_OFS = 1,
   parameter int unsigned LW       = 16
) (
   input  logic         clk,
   input  logic         rst_n,
   chnl_accum_if.slave  bus
);
   typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_HOLD} state_t;

   state_t                 state, state_nx;
   logic                   run_start;
   logic                   beat;
   logic                   last_beat;
   logic                   in_ready;
   logic                   out_valid;
   logic                   busy;
   logic [NO-1:0][OW-1:0]  acc;
   logic [NO-1:0][OW-1:0]  lane_sum;
   logic [NO-1:0]          ovf;
   logic [NO-1:0]          lane_ovf;
   logic [LW-1:0]          cnt;
   logic [LW-1:0]          len;
   logic                   sat;
   logic                   unused_din;

   // Lanes outside the accumulated window are intentionally ignored.
   assign unused_din = ^bus.din;

   assign beat      = bus.in_valid & in_ready;
   assign last_beat = (cnt == len - LW'(1));

   assign bus.in_ready  = in_ready;
   assign bus.out_valid = out_valid;
   assign bus.busy      = busy;
   assign bus.dout      = acc;
   assign bus.ovf       = ovf;

   // Run state register.
   always_ff @(posedge clk) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= state_nx;
   end

   // Next-state, run-start strobe and handshake outputs.
   always_comb begin
      state_nx  = state;
      run_start = 1'b0;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      busy      = 1'b0;
      unique case (state)
         S_IDLE: begin
            if (bus.start) begin
               state_nx  = S_ACCUM;
               run_start = 1'b1;
            end
         end
         S_ACCUM: begin
            in_ready = 1'b1;
            busy     = 1'b1;
            if (bus.in_valid && last_beat) state_nx = S_HOLD;
         end
         S_HOLD: begin
            out_valid = 1'b1;
            busy      = 1'b1;
            if (bus.out_ready) begin
               if (bus.start) begin
                  state_nx  = S_ACCUM;
                  run_start = 1'b1;
               end else begin
                  state_nx = S_IDLE;
               end
            end
         end
         default: state_nx = S_IDLE;
      endcase
   end

   // Per-lane OW+1 bit add; on overflow the carry bit picks the clamp direction.
   always_comb begin
      logic [IW-1:0] d;
      logic [OW:0]   s;
      d        = '0;
      s        = '0;
      lane_sum = '0;
      lane_ovf = '0;
      for (int unsigned i = 0; i < NO; i++) begin
         d = bus.din[(i + LANE_OFS)*IW +: IW];
         s = {acc[i][OW-1], acc[i]} + {{(OW+1-IW){d[IW-1]}}, d};
         lane_ovf[i] = s[OW] ^ s[OW-1];
         if (lane_ovf[i] && sat) lane_sum[i] = {s[OW], {(OW-1){~s[OW]}}};
         else                    lane_sum[i] = s[OW-1:0];
      end
   end

   // Accumulators, sticky overflow, beat counter and latched run config.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         acc <= '0;
         ovf <= '0;
         cnt <= '0;
         len <= '0;
         sat <= 1'b0;
      end else if (run_start) begin
         acc <= '0;
         ovf <= '0;
         cnt <= '0;
         len <= (bus.cfg_len == '0) ? LW'(1) : bus.cfg_len;
         sat <= bus.cfg_sat;
      end else if (beat) begin
         acc <= lane_sum;
         ovf <= ovf | lane_ovf;
         cnt <= cnt + LW'(1);
      end
   end
endmodule

// File: tb/tb_chnl_accum.sv
// tb_chnl_accum: directed and randomized runs against an integer reference model of
// the per-lane window sum with wrap/saturate and sticky overflow.
`timescale 1ns/1ps
module tb_chnl_accum;
   localparam int unsigned NI = 9;
   localparam int unsigned IW = 32;
   localparam int unsigned NO = 7;
   localparam int unsigned OW = 32;
   localparam int unsigned LANE_OFS = 1;
   localparam int unsigned LW = 16;
   localparam longint SMAX = (longint'(1) <<< (OW-1)) - 1;
   localparam longint SMIN = -(longint'(1) <<< (OW-1));
   localparam longint SPAN = longint'(1) <<< OW;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   vectors = 0;
   int   miscompares = 0;

   chnl_accum_if #(.NI(NI), .IW(IW), .NO(NO), .OW(OW), .LW(LW)) bus ();

   chnl_accum #(.NI(NI), .IW(IW), .NO(NO), .OW(OW), .LANE_OFS(LANE_OFS), .LW(LW)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   always #5 clk = ~clk;

   // Reference model: exact integer sums per lane.
   longint        m_acc [NO];
   logic [NO-1:0] m_ovf;
   bit            m_sat;

   function automatic void m_start(input bit sat);
      for (int i = 0; i < NO; i++) m_acc[i] = 0;
      m_ovf = '0;
      m_sat = sat;
   endfunction

   function automatic void m_beat(input logic [NI*IW-1:0] d);
      logic [IW-1:0] lane;
      longint s;
      for (int i = 0; i < NO; i++) begin
         lane = d[(i+LANE_OFS)*IW +: IW];
         s = m_acc[i] + longint'($signed(lane));
         if (s > SMAX || s < SMIN) begin
            m_ovf[i] = 1'b1;
            if (m_sat) s = (s > SMAX) ? SMAX : SMIN;
            else       s = (s > SMAX) ? s - SPAN : s + SPAN;
         end
         m_acc[i] = s;
      end
   endfunction

   function automatic logic [NO*OW-1:0] m_dout();
      logic [NO*OW-1:0] r;
      logic [63:0] t;
      r = '0;
      for (int i = 0; i < NO; i++) begin
         t = m_acc[i];
         r[i*OW +: OW] = t[OW-1:0];
      end
      return r;
   endfunction

   function automatic logic [NI*IW-1:0] rand_din();
      logic [NI*IW-1:0] r;
      int v;
      bit big;
      big = ($urandom_range(0, 1) == 1);
      for (int k = 0; k < NI; k++) begin
         if (big) r[k*IW +: IW] = IW'($urandom);
         else begin
            v = int'($urandom_range(0, 200)) - 100;
            r[k*IW +: IW] = IW'(v);
         end
      end
      return r;
   endfunction

   function automatic logic [NI*IW-1:0] lane1_din(input logic [IW-1:0] v);
      logic [NI*IW-1:0] r;
      r = '0;
      r[LANE_OFS*IW +: IW] = v;
      return r;
   endfunction

   task automatic check(input string tag, input logic [NO*OW-1:0] obs, input logic [NO*OW-1:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic start_idle(input logic [LW-1:0] len, input bit sat);
      bus.start   = 1'b1;
      bus.cfg_len = len;
      bus.cfg_sat = sat;
      m_start(sat);
      tick();
      bus.start   = 1'b0;
      bus.cfg_len = LW'($urandom);
      bus.cfg_sat = 1'($urandom);
      check("busy_after_start", bus.busy, 1);
      check("in_ready_after_start", bus.in_ready, 1);
      check("acc_cleared_on_start", bus.dout, '0);
   endtask

   task automatic push_beat(input logic [NI*IW-1:0] d, input int gaps, input bit rnd);
      repeat (gaps) begin
         bus.in_valid  = 1'b0;
         bus.din       = rand_din();
         bus.start     = rnd && ($urandom_range(0, 3) == 0);
         bus.out_ready = rnd && ($urandom_range(0, 1) == 1);
         tick();
      end
      bus.in_valid  = 1'b1;
      bus.din       = d;
      bus.start     = rnd && ($urandom_range(0, 3) == 0);
      bus.out_ready = rnd && ($urandom_range(0, 1) == 1);
      check("in_ready_accum", bus.in_ready, 1);
      check("out_valid_accum", bus.out_valid, 0);
      m_beat(d);
      tick();
      bus.in_valid  = 1'b0;
      bus.start     = 1'b0;
      bus.out_ready = 1'b0;
   endtask

   task automatic hold(input int bp, input bit b2b, input logic [LW-1:0] len, input bit sat);
      check("out_valid_hold", bus.out_valid, 1);
      check("in_ready_hold", bus.in_ready, 0);
      check("dout_result", bus.dout, m_dout());
      check("ovf_result", bus.ovf, m_ovf);
      repeat (bp) begin
         bus.out_ready = 1'b0;
         bus.start     = 1'($urandom);
         bus.in_valid  = 1'($urandom);
         bus.din       = rand_din();
         tick();
         check("out_valid_backpressure", bus.out_valid, 1);
         check("dout_stable_hold", bus.dout, m_dout());
      end
      bus.out_ready = 1'b1;
      bus.start     = b2b;
      bus.cfg_len   = len;
      bus.cfg_sat   = sat;
      bus.in_valid  = 1'($urandom);
      tick();
      bus.out_ready = 1'b0;
      bus.start     = 1'b0;
      bus.in_valid  = 1'b0;
      check("out_valid_after_hs", bus.out_valid, 0);
      check("busy_after_hs", bus.busy, b2b);
      if (b2b) begin
         m_start(sat);
         check("b2b_acc_cleared", bus.dout, '0);
         check("b2b_in_ready", bus.in_ready, 1);
      end else begin
         check("dout_kept_idle", bus.dout, m_dout());
      end
   endtask

   initial begin
      logic [NI*IW-1:0] d;
      logic [LW-1:0]    cur_len, nxt_len;
      bit               cur_sat, nxt_sat, started, b2b;
      int               eff;

      bus.start = 1'b0; bus.cfg_len = '0; bus.cfg_sat = 1'b0;
      bus.in_valid = 1'b0; bus.din = '0; bus.out_ready = 1'b0;
      rst_n = 1'b0;
      repeat (3) tick();
      check("rst_out_valid", bus.out_valid, 0);
      check("rst_in_ready", bus.in_ready, 0);
      check("rst_busy", bus.busy, 0);
      check("rst_dout", bus.dout, '0);
      check("rst_ovf", bus.ovf, '0);
      rst_n = 1'b1;
      tick();
      check("idle_busy", bus.busy, 0);

      // T1: reset mid-run after 3 beats
      start_idle(10, 1'b0);
      for (int b = 0; b < 3; b++) push_beat(rand_din(), 0, 1'b0);
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      check("t1_busy", bus.busy, 0);
      check("t1_in_ready", bus.in_ready, 0);
      check("t1_out_valid", bus.out_valid, 0);
      check("t1_dout", bus.dout, '0);
      check("t1_ovf", bus.ovf, '0);

      // T2: lane k carries k+1, four beats
      for (int k = 0; k < NI; k++) d[k*IW +: IW] = IW'(k + 1);
      start_idle(4, 1'b0);
      for (int b = 0; b < 4; b++) push_beat(d, 0, 1'b0);
      check("t2_lane0", bus.dout[0 +: OW], 8);
      check("t2_lane6", bus.dout[6*OW +: OW], 32);
      check("t2_ovf", bus.ovf, '0);
      hold(0, 1'b0, '0, 1'b0);

      // T3: in_valid 1,0,0,1,0,1 then 5 cycles of backpressure
      start_idle(3, 1'b0);
      push_beat(rand_din(), 0, 1'b0);
      push_beat(rand_din(), 2, 1'b0);
      push_beat(rand_din(), 1, 1'b0);
      hold(5, 1'b0, '0, 1'b0);

      // T4: saturation, wrap, negative clamp, sticky flag
      start_idle(2, 1'b1);
      push_beat(lane1_din(32'h7FFF_FFFF), 0, 1'b0);
      push_beat(lane1_din(32'h0000_0001), 0, 1'b0);
      check("t4_sat_pos", bus.dout[0 +: OW], 32'h7FFF_FFFF);
      check("t4_sat_ovf", bus.ovf, 7'b000_0001);
      hold(0, 1'b0, '0, 1'b0);
      start_idle(2, 1'b0);
      push_beat(lane1_din(32'h7FFF_FFFF), 0, 1'b0);
      push_beat(lane1_din(32'h0000_0001), 0, 1'b0);
      check("t4_wrap", bus.dout[0 +: OW], 32'h8000_0000);
      check("t4_wrap_ovf", bus.ovf, 7'b000_0001);
      hold(0, 1'b0, '0, 1'b0);
      start_idle(2, 1'b1);
      push_beat(lane1_din(32'h8000_0000), 0, 1'b0);
      push_beat(lane1_din(32'hFFFF_FFFF), 0, 1'b0);
      check("t4_sat_neg", bus.dout[0 +: OW], 32'h8000_0000);
      hold(0, 1'b0, '0, 1'b0);
      start_idle(3, 1'b1);
      push_beat(lane1_din(32'h7FFF_FFFF), 0, 1'b0);
      push_beat(lane1_din(32'h0000_0001), 0, 1'b0);
      push_beat(lane1_din(32'hFFFF_FFFB), 0, 1'b0);
      check("t4_sticky_val", bus.dout[0 +: OW], 32'h7FFF_FFFA);
      check("t4_sticky_ovf", bus.ovf, 7'b000_0001);
      hold(0, 1'b0, '0, 1'b0);

      // T5: back-to-back start in HOLD with cfg_len=0, start ignored in ACCUM
      start_idle(2, 1'b0);
      push_beat(rand_din(), 0, 1'b1);
      push_beat(rand_din(), 0, 1'b1);
      hold(1, 1'b1, '0, 1'b0);
      push_beat(rand_din(), 0, 1'b1);
      hold(0, 1'b0, '0, 1'b0);

      // T6: randomized runs
      started = 1'b0;
      cur_len = LW'($urandom_range(1, 64));
      cur_sat = 1'($urandom);
      for (int r = 0; r < 1000; r++) begin
         if (!started) begin
            repeat ($urandom_range(0, 2)) begin
               bus.out_ready = 1'($urandom);
               tick();
               check("idle_out_valid", bus.out_valid, 0);
            end
            bus.out_ready = 1'b0;
            start_idle(cur_len, cur_sat);
         end
         eff = (cur_len == '0) ? 1 : int'(cur_len);
         for (int b = 0; b < eff; b++)
            push_beat(rand_din(), ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 2)) : 0, 1'b1);
         nxt_len = LW'($urandom_range(0, 64));
         nxt_sat = 1'($urandom);
         b2b     = ($urandom_range(0, 2) == 0);
         hold(int'($urandom_range(0, 4)), b2b, nxt_len, nxt_sat);
         started = b2b;
         cur_len = nxt_len;
         cur_sat = nxt_sat;
      end
      if (started) begin
         eff = (cur_len == '0) ? 1 : int'(cur_len);
         for (int b = 0; b < eff; b++) push_beat(rand_din(), 0, 1'b0);
         hold(0, 1'b0, '0, 1'b0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
